// File: rtl/pseudo_spi_scan_rx_pkg.sv
// Shared definitions for the pseudo-SPI scan read-back path: sizes, FSM state codes
// and the four scan clock phases of a bit slot.
package pseudo_spi_scan_rx_pkg;

  localparam int MEM_DATA_W = 8;
  localparam int MEM_ADDR_W = 9;
  localparam int DATA_LEN_W = 8;
  localparam int FREQ_DIV_W = 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CAPT = 3'd1;
  localparam logic [2:0] ST_SHIF = 3'd2;
  localparam logic [2:0] ST_WRIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [1:0] {
    PH_SCLK1 = 2'd0,
    PH_GAP1  = 2'd1,
    PH_SCLK2 = 2'd2,
    PH_GAP2  = 2'd3
  } scan_phase_e;

  function automatic scan_phase_e next_phase(input scan_phase_e ph);
    case (ph)
      PH_SCLK1: next_phase = PH_GAP1;
      PH_GAP1:  next_phase = PH_SCLK2;
      PH_SCLK2: next_phase = PH_GAP2;
      PH_GAP2:  next_phase = PH_SCLK1;
      default:  next_phase = PH_SCLK1;
    endcase
  endfunction

endpackage

// File: rtl/pseudo_spi_scan_rx_phase_gen.sv
// Bit-slot generator: FREQ_DIV divider plus phase counter producing non-overlapping
// SCLK1/SCLK2 pulses; o_slot_start marks an edge at which a new slot may begin.
module pseudo_spi_scan_rx_phase_gen
  import pseudo_spi_scan_rx_pkg::*;
#(
  parameter int DIV_W = FREQ_DIV_W
) (
  input  logic             i_clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_run,
  input  logic [DIV_W-1:0] i_freq_div,
  output logic             o_sclk1,
  output logic             o_sclk2,
  output logic             o_slot_start
);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic             r_busy, w_busy_nxt;
  scan_phase_e      r_phase, w_phase_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_sclk1, w_sclk1_nxt;
  logic             r_sclk2, w_sclk2_nxt;
  logic             w_phase_end;
  logic             w_slot_end;

  assign w_phase_end  = (r_div == i_freq_div);
  assign w_slot_end   = r_busy && w_phase_end && (r_phase == PH_GAP2);
  assign o_slot_start = !r_busy || w_slot_end;
  assign o_sclk1      = r_sclk1;
  assign o_sclk2      = r_sclk2;

  // Next-state logic; a restart in the last cycle of a slot chains slots back to back
  always_comb begin
    w_busy_nxt  = r_busy;
    w_phase_nxt = r_phase;
    w_div_nxt   = r_div;
    w_sclk1_nxt = r_sclk1;
    w_sclk2_nxt = r_sclk2;
    if (i_clr) begin
      w_busy_nxt  = 1'b0;
      w_phase_nxt = PH_SCLK1;
      w_div_nxt   = DIV_ZERO;
      w_sclk1_nxt = 1'b0;
      w_sclk2_nxt = 1'b0;
    end else if (i_run && o_slot_start) begin
      w_busy_nxt  = 1'b1;
      w_phase_nxt = PH_SCLK1;
      w_div_nxt   = DIV_ZERO;
      w_sclk1_nxt = 1'b1;
      w_sclk2_nxt = 1'b0;
    end else if (r_busy) begin
      if (w_phase_end) begin
        w_div_nxt   = DIV_ZERO;
        w_phase_nxt = next_phase(r_phase);
        w_busy_nxt  = (r_phase != PH_GAP2);
        w_sclk1_nxt = 1'b0;
        w_sclk2_nxt = (r_phase == PH_GAP1);
      end else begin
        w_div_nxt = r_div + DIV_ONE;
      end
    end else begin
      w_busy_nxt = 1'b0;
    end
  end

  // Slot state and scan clock registers
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_phase <= PH_SCLK1;
      r_div   <= DIV_ZERO;
      r_sclk1 <= 1'b0;
      r_sclk2 <= 1'b0;
    end else begin
      r_busy  <= w_busy_nxt;
      r_phase <= w_phase_nxt;
      r_div   <= w_div_nxt;
      r_sclk1 <= w_sclk1_nxt;
      r_sclk2 <= w_sclk2_nxt;
    end
  end

endmodule

// File: rtl/pseudo_spi_scan_rx.sv
// Scan-chain read-back: one capture slot with SEL high, then shifts the chain out,
// packs SPI_SI into bytes (first bit in LSB) and writes them to SRAM at descending addresses.
module pseudo_spi_scan_rx
  import pseudo_spi_scan_rx_pkg::*;
#(
  parameter int MEMORY_DATA_WIDTH = MEM_DATA_W,
  parameter int MEMORY_ADDR_WIDTH = MEM_ADDR_W,
  parameter int RESERVED_DATA_LEN = DATA_LEN_W
) (
  input  logic                         i_clk,
  input  logic                         rst_n,
  input  logic                         i_bgn,
  input  logic [MEMORY_ADDR_WIDTH-1:0] i_addr_bgn,
  input  logic [RESERVED_DATA_LEN-1:0] i_data_len,
  input  logic [FREQ_DIV_W-1:0]        i_freq_div,
  input  logic                         i_spi_si,
  output logic                         o_sclk1,
  output logic                         o_sclk2,
  output logic                         o_sel,
  output logic                         o_cen,
  output logic                         o_d_we,
  output logic [MEMORY_ADDR_WIDTH-1:0] o_a,
  output logic [MEMORY_DATA_WIDTH-1:0] o_po,
  output logic                         o_spi_is_done
);

  localparam int DW  = MEMORY_DATA_WIDTH;
  localparam int AW  = MEMORY_ADDR_WIDTH;
  localparam int LW  = RESERVED_DATA_LEN;
  localparam int BCW = $clog2(DW);

  localparam logic [AW-1:0]  ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]  BYTE_ONE = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0] BIT_ONE  = {{(BCW-1){1'b0}}, 1'b1};
  localparam logic [BCW-1:0] BIT_ZERO = {BCW{1'b0}};
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DW - 1);

  logic [2:0]            r_state, w_state_nxt;
  logic [AW-1:0]         r_addr, w_addr_nxt;
  logic [LW-1:0]         r_data_len, w_data_len_nxt;
  logic [LW-1:0]         r_byte_cnt, w_byte_cnt_nxt;
  logic [FREQ_DIV_W-1:0] r_freq_div, w_freq_div_nxt;
  logic [BCW-1:0]        r_bit_cnt, w_bit_cnt_nxt;
  logic [DW-1:0]         r_shreg, w_shreg_nxt;
  logic                  r_sel, w_sel_nxt;
  logic                  r_cen, w_cen_nxt;
  logic                  r_d_we, w_d_we_nxt;
  logic [AW-1:0]         r_a, w_a_nxt;
  logic [DW-1:0]         r_po, w_po_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_run;
  logic                  w_slot_start;
  logic                  w_sclk1;
  logic                  w_sclk2;
  logic [DW-1:0]         w_shifted;
  logic                  w_last_byte;

  assign w_shifted   = {i_spi_si, r_shreg[DW-1:1]};
  assign w_last_byte = (r_byte_cnt == r_data_len);

  pseudo_spi_scan_rx_phase_gen #(
    .DIV_W (FREQ_DIV_W)
  ) u_phase_gen (
    .i_clk        (i_clk),
    .rst_n        (rst_n),
    .i_clr        (!i_bgn),
    .i_run        (w_run),
    .i_freq_div   (r_freq_div),
    .o_sclk1      (w_sclk1),
    .o_sclk2      (w_sclk2),
    .o_slot_start (w_slot_start)
  );

  // Read-back FSM; every slot boundary in SHIF samples SPI_SI before the next SCLK1 phase
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_data_len_nxt = r_data_len;
    w_byte_cnt_nxt = r_byte_cnt;
    w_freq_div_nxt = r_freq_div;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_shreg_nxt    = r_shreg;
    w_sel_nxt      = r_sel;
    w_cen_nxt      = 1'b1;
    w_d_we_nxt     = 1'b0;
    w_a_nxt        = r_a;
    w_po_nxt       = r_po;
    w_done_nxt     = r_done;
    w_run          = 1'b0;
    if (!i_bgn) begin
      w_state_nxt    = ST_IDLE;
      w_byte_cnt_nxt = {LW{1'b0}};
      w_bit_cnt_nxt  = BIT_ZERO;
      w_shreg_nxt    = {DW{1'b0}};
      w_sel_nxt      = 1'b0;
      w_a_nxt        = {AW{1'b0}};
      w_po_nxt       = {DW{1'b0}};
      w_done_nxt     = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt    = ST_CAPT;
          w_addr_nxt     = i_addr_bgn;
          w_data_len_nxt = i_data_len;
          w_freq_div_nxt = i_freq_div;
          w_byte_cnt_nxt = {LW{1'b0}};
          w_bit_cnt_nxt  = BIT_ZERO;
          w_shreg_nxt    = {DW{1'b0}};
          w_sel_nxt      = 1'b1;
          w_run          = 1'b1;
        end
        ST_CAPT: begin
          if (w_slot_start) begin
            w_state_nxt   = ST_SHIF;
            w_sel_nxt     = 1'b0;
            w_shreg_nxt   = w_shifted;
            w_bit_cnt_nxt = BIT_ONE;
            w_run         = 1'b1;
          end else begin
            w_run = 1'b0;
          end
        end
        ST_SHIF: begin
          if (!w_slot_start) begin
            w_run = 1'b0;
          end else if (r_bit_cnt == BIT_ZERO) begin
            // Byte complete and the next bit already shifted to SO
            w_state_nxt = ST_WRIT;
            w_cen_nxt   = 1'b0;
            w_d_we_nxt  = 1'b1;
            w_a_nxt     = r_addr;
            w_po_nxt    = r_shreg;
          end else if ((r_bit_cnt == BIT_LAST) && w_last_byte) begin
            // Final bit of the run: no trailing SCLK pulse
            w_state_nxt   = ST_WRIT;
            w_shreg_nxt   = w_shifted;
            w_bit_cnt_nxt = BIT_ZERO;
            w_cen_nxt     = 1'b0;
            w_d_we_nxt    = 1'b1;
            w_a_nxt       = r_addr;
            w_po_nxt      = w_shifted;
          end else begin
            w_shreg_nxt   = w_shifted;
            w_bit_cnt_nxt = r_bit_cnt + BIT_ONE;
            w_run         = 1'b1;
          end
        end
        ST_WRIT: begin
          if (w_last_byte) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt    = ST_SHIF;
            w_addr_nxt     = r_addr - ADDR_ONE;
            w_byte_cnt_nxt = r_byte_cnt + BYTE_ONE;
            w_shreg_nxt    = w_shifted;
            w_bit_cnt_nxt  = BIT_ONE;
            w_run          = 1'b1;
          end
        end
        ST_DONE: begin
          w_done_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_addr     <= {AW{1'b0}};
      r_data_len <= {LW{1'b0}};
      r_byte_cnt <= {LW{1'b0}};
      r_freq_div <= {FREQ_DIV_W{1'b0}};
      r_bit_cnt  <= BIT_ZERO;
      r_shreg    <= {DW{1'b0}};
      r_sel      <= 1'b0;
      r_cen      <= 1'b1;
      r_d_we     <= 1'b0;
      r_a        <= {AW{1'b0}};
      r_po       <= {DW{1'b0}};
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_data_len <= w_data_len_nxt;
      r_byte_cnt <= w_byte_cnt_nxt;
      r_freq_div <= w_freq_div_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_shreg    <= w_shreg_nxt;
      r_sel      <= w_sel_nxt;
      r_cen      <= w_cen_nxt;
      r_d_we     <= w_d_we_nxt;
      r_a        <= w_a_nxt;
      r_po       <= w_po_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_sclk1       = w_sclk1;
  assign o_sclk2       = w_sclk2;
  assign o_sel         = r_sel;
  assign o_cen         = r_cen;
  assign o_d_we        = r_d_we;
  assign o_a           = r_a;
  assign o_po          = r_po;
  assign o_spi_is_done = r_done;

endmodule

// File: tb/tb_pseudo_spi_scan_rx.sv
// Directed bench for pseudo_spi_scan_rx: scan-chain model, SRAM model and a queue of
// expected (address, data) writes compared as the DUT issues them.
module tb_pseudo_spi_scan_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bgn;
  logic [8:0] addr_bgn;
  logic [7:0] data_len;
  logic [7:0] freq_div;
  logic       spi_si;
  logic       sclk1, sclk2, sel, cen, d_we, done;
  logic [8:0] a;
  logic [7:0] po;

  logic [23:0] pin;
  logic [23:0] chain = 24'd0;
  logic [7:0]  mem [0:511];
  logic [16:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_pulse = 0, n_badw = 0, n_overlap = 0, n_sel = 0;
  int sclk1_w = 0;
  int exp_w = 1;
  int base_wr, base_pulse, base_badw, base_ovl, base_sel;

  always #5 clk = ~clk;

  pseudo_spi_scan_rx dut (
    .i_clk         (clk),
    .rst_n         (rst_n),
    .i_bgn         (bgn),
    .i_addr_bgn    (addr_bgn),
    .i_data_len    (data_len),
    .i_freq_div    (freq_div),
    .i_spi_si      (spi_si),
    .o_sclk1       (sclk1),
    .o_sclk2       (sclk2),
    .o_sel         (sel),
    .o_cen         (cen),
    .o_d_we        (d_we),
    .o_a           (a),
    .o_po          (po),
    .o_spi_is_done (done)
  );

  // Scan chain: cell 0 drives SO; SCLK2 completes a capture (SEL=1) or a shift
  always @(posedge sclk2) begin
    if (sel) chain <= pin;
    else     chain <= {1'b0, chain[23:1]};
  end
  assign spi_si = chain[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sclk1"}, {31'd0, sclk1}, 32'd0);
    check({tag, "_sclk2"}, {31'd0, sclk2}, 32'd0);
    check({tag, "_sel"},   {31'd0, sel},   32'd0);
    check({tag, "_cen"},   {31'd0, cen},   32'd1);
    check({tag, "_d_we"},  {31'd0, d_we},  32'd0);
    check({tag, "_a"},     {23'd0, a},     32'd0);
    check({tag, "_po"},    {24'd0, po},    32'd0);
    check({tag, "_done"},  {31'd0, done},  32'd0);
  endtask

  // One cycle: observe on the falling edge, track pulses and score SRAM writes
  task automatic tick();
    logic [16:0] e;
    @(negedge clk);
    if (sclk1 && sclk2) n_overlap++;
    if (sel) n_sel++;
    if (sclk1) sclk1_w++;
    else if (sclk1_w != 0) begin
      n_pulse++;
      if (sclk1_w != exp_w) n_badw++;
      sclk1_w = 0;
    end
    if (cen === 1'b0 && d_we === 1'b1) begin
      n_wr++;
      mem[a] = po;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", {23'd0, a}, {23'd0, e[16:8]});
        check("wr_data", {24'd0, po}, {24'd0, e[7:0]});
      end
    end
  endtask

  task automatic push_run(input logic [8:0] addr, input int len, input logic [23:0] v);
    logic [8:0] ad;
    for (int k = 0; k <= len; k++) begin
      ad = addr - 9'(k);
      exp_q.push_back({ad, v[8*k +: 8]});
    end
  endtask

  task automatic start(input logic [8:0] ad, input logic [7:0] len, input logic [7:0] fd,
                       input logic [23:0] v);
    pin = v; addr_bgn = ad; data_len = len; freq_div = fd;
    exp_w = int'(fd) + 1;
    base_wr = n_wr; base_pulse = n_pulse; base_badw = n_badw;
    base_ovl = n_overlap; base_sel = n_sel;
    bgn = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic stop_run(input string tag);
    bgn = 1'b0;
    tick();
    check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int wait_n;
    rst_n = 1'b0; bgn = 1'b0; addr_bgn = 9'd0; data_len = 8'd0; freq_div = 8'd0;
    pin = 24'd0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    #12;
    check_idle("reset");
    tick();
    rst_n = 1'b1;
    tick();

    // Basic read-back, with BGN-to-SCLK1 latency
    push_run(9'd1, 1, 24'h00A5C3);
    start(9'd1, 8'd1, 8'd0, 24'h00A5C3);
    @(posedge clk); #1;
    check("lat_sclk1", {31'd0, sclk1}, 32'd1);
    check("lat_sel", {31'd0, sel}, 32'd1);
    wait_done("basic", 2000);
    check("basic_writes", n_wr - base_wr, 32'd2);
    check("basic_q_empty", exp_q.size(), 32'd0);
    check("basic_mem1", {24'd0, mem[1]}, 32'h0000_00C3);
    check("basic_mem0", {24'd0, mem[0]}, 32'h0000_00A5);
    check("basic_pulses", n_pulse - base_pulse, 32'd16);
    base_pulse = n_pulse;
    for (int i = 0; i < 20; i++) tick();
    check("hold_no_restart", n_pulse - base_pulse, 32'd0);
    check("hold_done", {31'd0, done}, 32'd1);
    stop_run("basic");

    // Timing with FREQ_DIV=3, single byte; inputs changed mid-run are ignored
    push_run(9'd5, 0, 24'h000F3C);
    start(9'd5, 8'd0, 8'd3, 24'h000F3C);
    for (int i = 0; i < 5; i++) tick();
    addr_bgn = 9'd100; data_len = 8'd7; freq_div = 8'd0;
    wait_done("timing", 2000);
    check("timing_writes", n_wr - base_wr, 32'd1);
    check("timing_mem5", {24'd0, mem[5]}, 32'h0000_003C);
    check("timing_pulses", n_pulse - base_pulse, 32'd8);
    check("timing_badw", n_badw - base_badw, 32'd0);
    check("timing_overlap", n_overlap - base_ovl, 32'd0);
    check("timing_sel_cyc", n_sel - base_sel, 32'd16);
    check("timing_q_empty", exp_q.size(), 32'd0);
    stop_run("timing");

    // Address wrap 0 -> 511 -> 510
    push_run(9'd0, 2, 24'h5A6996);
    start(9'd0, 8'd2, 8'd0, 24'h5A6996);
    wait_done("wrap", 3000);
    check("wrap_writes", n_wr - base_wr, 32'd3);
    check("wrap_mem511", {24'd0, mem[511]}, 32'h0000_0069);
    check("wrap_mem510", {24'd0, mem[510]}, 32'h0000_005A);
    check("wrap_q_empty", exp_q.size(), 32'd0);
    stop_run("wrap");

    // Abort after 5 bits of byte 0
    start(9'd7, 8'd1, 8'd0, 24'h00FFFF);
    wait_n = 0;
    while ((n_pulse - base_pulse) < 6 && wait_n < 500) begin
      tick();
      wait_n++;
    end
    check("abort_reach", n_pulse - base_pulse, 32'd6);
    bgn = 1'b0;
    @(posedge clk); #1;
    check_idle("abort");
    for (int i = 0; i < 40; i++) tick();
    check("abort_no_write", n_wr - base_wr, 32'd0);

    // Reset mid-shift, then a fresh run
    start(9'd1, 8'd1, 8'd0, 24'h00A5C3);
    for (int i = 0; i < 20; i++) tick();
    #2 rst_n = 1'b0;
    #1 check_idle("rst_mid");
    bgn = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    rst_n = 1'b1;
    tick();
    check("rst_no_write", n_wr - base_wr, 32'd0);
    mem[0] = 8'h00; mem[1] = 8'h00;
    push_run(9'd1, 1, 24'h00A5C3);
    start(9'd1, 8'd1, 8'd0, 24'h00A5C3);
    wait_done("rerun", 2000);
    check("rerun_writes", n_wr - base_wr, 32'd2);
    check("rerun_mem1", {24'd0, mem[1]}, 32'h0000_00C3);
    check("rerun_mem0", {24'd0, mem[0]}, 32'h0000_00A5);
    check("rerun_q_empty", exp_q.size(), 32'd0);
    stop_run("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
